sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter.sv | 134 +++++++++++++
 tb/tb_sram_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter driving a 256Kx16 asynchronous SRAM.
// Each access runs IDLE -> SETUP -> STROBE (ACCESS_CYCLES) -> RECOVER with registered outputs.
module sram_arbiter #(
   parameter int unsigned ACCESS_CYCLES = 2
) (
   input  logic        CLOCK_50,
   input  logic        RESET,
   input  logic        A_REQ,
   input  logic        A_WE,
   input  logic [17:0] A_ADDR,
   input  logic [15:0] A_WDATA,
   input  logic [1:0]  A_BE,
   output logic        A_ACK,
   output logic [15:0] A_RDATA,
   input  logic        B_REQ,
   input  logic        B_WE,
   input  logic [17:0] B_ADDR,
   input  logic [15:0] B_WDATA,
   input  logic [1:0]  B_BE,
   output logic        B_ACK,
   output logic [15:0] B_RDATA,
   output logic [17:0] SRAM_ADDR,
   inout  wire  [15:0] SRAM_DQ,
   output logic        SRAM_WE_N,
   output logic        SRAM_OE_N,
   output logic        SRAM_UB_N,
   output logic        SRAM_LB_N,
   output logic        SRAM_CE_N,
   output logic        BUSY
);

   typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_STROBE, ST_RECOVER} state_t;

   localparam logic [3:0] LP_CNT_LAST = 4'(ACCESS_CYCLES - 1);

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic        r_last_b;
   logic        r_grant_b;
   logic        r_we;
   logic [15:0] r_wdata;
   logic [1:0]  r_be;
   logic        r_dq_oe;

   logic        w_grant_b;
   logic        w_we;
   logic [17:0] w_addr;
   logic [15:0] w_wdata;
   logic [1:0]  w_be;

   // B wins when it is the only requester, or on a tie when A was granted last.
   assign w_grant_b = B_REQ & (~A_REQ | ~r_last_b);
   assign w_we      = w_grant_b ? B_WE    : A_WE;
   assign w_addr    = w_grant_b ? B_ADDR  : A_ADDR;
   assign w_wdata   = w_grant_b ? B_WDATA : A_WDATA;
   assign w_be      = w_grant_b ? B_BE    : A_BE;

   assign SRAM_DQ = r_dq_oe ? r_wdata : 'z;

   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_last_b  <= 1'b1;
         r_grant_b <= 1'b0;
         r_we      <= 1'b0;
         r_wdata   <= '0;
         r_be      <= '0;
         r_dq_oe   <= 1'b0;
         SRAM_ADDR <= '0;
         SRAM_CE_N <= 1'b1;
         SRAM_WE_N <= 1'b1;
         SRAM_OE_N <= 1'b1;
         SRAM_UB_N <= 1'b1;
         SRAM_LB_N <= 1'b1;
         A_ACK     <= 1'b0;
         B_ACK     <= 1'b0;
         A_RDATA   <= '0;
         B_RDATA   <= '0;
         BUSY      <= 1'b0;
      end else begin
         A_ACK <= 1'b0;
         B_ACK <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (A_REQ || B_REQ) begin
                  r_grant_b <= w_grant_b;
                  r_last_b  <= w_grant_b;
                  r_we      <= w_we;
                  r_wdata   <= w_wdata;
                  r_be      <= w_be;
                  r_dq_oe   <= w_we;
                  SRAM_ADDR <= w_addr;
                  SRAM_CE_N <= 1'b0;
                  SRAM_UB_N <= w_we ? ~w_be[1] : 1'b0;
                  SRAM_LB_N <= w_we ? ~w_be[0] : 1'b0;
                  BUSY      <= 1'b1;
                  r_state   <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               r_cnt     <= LP_CNT_LAST;
               // A write with no byte enables keeps WE_N high so the SRAM is untouched.
               SRAM_WE_N <= ~(r_we & |r_be);
               SRAM_OE_N <= r_we;
               r_state   <= ST_STROBE;
            end
            ST_STROBE: begin
               if (r_cnt == 4'd0) begin
                  SRAM_WE_N <= 1'b1;
                  SRAM_OE_N <= 1'b1;
                  A_ACK     <= ~r_grant_b;
                  B_ACK     <= r_grant_b;
                  if (!r_we && !r_grant_b) A_RDATA <= SRAM_DQ;
                  if (!r_we &&  r_grant_b) B_RDATA <= SRAM_DQ;
                  r_state   <= ST_RECOVER;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            ST_RECOVER: begin
               SRAM_CE_N <= 1'b1;
               SRAM_UB_N <= 1'b1;
               SRAM_LB_N <= 1'b1;
               r_dq_oe   <= 1'b0;
               BUSY      <= 1'b0;
               r_state   <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural byte-lane SRAM model.
// A pull-up on the data bus makes an undriven bus read back as all ones.
module tb_sram_arbiter;

   localparam int unsigned AC       = 2;
   localparam logic [15:0] DQ_FLOAT = 16'hFFFF;

   logic        clk = 1'b0;
   logic        rst;
   logic        a_req, a_we, a_ack, b_req, b_we, b_ack;
   logic [17:0] a_addr, b_addr, sram_addr;
   logic [15:0] a_wdata, b_wdata, a_rdata, b_rdata;
   logic [1:0]  a_be, b_be;
   logic        we_n, oe_n, ub_n, lb_n, ce_n, busy;
   wire  [15:0] sram_dq;

   logic [15:0] mem [0:255];
   int          n_vec = 0;
   int          n_err = 0;
   int          viol  = 0;

   always #5 clk = ~clk;

   pullup (sram_dq);

   sram_arbiter #(.ACCESS_CYCLES(AC)) dut (
      .CLOCK_50 (clk),     .RESET    (rst),
      .A_REQ    (a_req),   .A_WE     (a_we),    .A_ADDR  (a_addr),
      .A_WDATA  (a_wdata), .A_BE     (a_be),    .A_ACK   (a_ack),   .A_RDATA (a_rdata),
      .B_REQ    (b_req),   .B_WE     (b_we),    .B_ADDR  (b_addr),
      .B_WDATA  (b_wdata), .B_BE     (b_be),    .B_ACK   (b_ack),   .B_RDATA (b_rdata),
      .SRAM_ADDR(sram_addr), .SRAM_DQ(sram_dq),
      .SRAM_WE_N(we_n),    .SRAM_OE_N(oe_n),   .SRAM_UB_N(ub_n),
      .SRAM_LB_N(lb_n),    .SRAM_CE_N(ce_n),   .BUSY    (busy)
   );

   assign sram_dq = (!ce_n && !oe_n && we_n) ? mem[sram_addr[7:0]] : 16'hzzzz;

   always @(posedge clk) begin
      if (!ce_n && !we_n) begin
         if (!ub_n) mem[sram_addr[7:0]][15:8] <= sram_dq[15:8];
         if (!lb_n) mem[sram_addr[7:0]][7:0]  <= sram_dq[7:0];
      end
   end

   always @(negedge clk) begin
      viol <= viol + int'(a_ack && b_ack) + int'(!we_n && !oe_n);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_req(input bit pb, input bit req, input bit we,
                            input logic [17:0] addr, input logic [15:0] wd, input logic [1:0] be);
      if (pb) begin
         b_req = req; b_we = we; b_addr = addr; b_wdata = wd; b_be = be;
      end else begin
         a_req = req; a_we = we; a_addr = addr; a_wdata = wd; a_be = be;
      end
   endtask

   // One uncontended access from IDLE, checked cycle by cycle.
   task automatic run_single(input bit pb, input bit we, input logic [17:0] addr,
                             input logic [15:0] wd, input logic [1:0] be, input logic [15:0] exp_rd);
      logic [15:0] own_rd, other_rd;
      logic        exp_ub, exp_lb, exp_wen;
      own_rd   = pb ? b_rdata : a_rdata;
      other_rd = pb ? a_rdata : b_rdata;
      exp_ub   = we ? ~be[1] : 1'b0;
      exp_lb   = we ? ~be[0] : 1'b0;
      exp_wen  = ~(we & |be);
      drive_req(pb, 1'b1, we, addr, wd, be);
      tick();
      chk("setup_busy", 32'(busy), 1);
      chk("setup_ce_n", 32'(ce_n), 0);
      chk("setup_we_n", 32'(we_n), 1);
      chk("setup_oe_n", 32'(oe_n), 1);
      chk("setup_addr", 32'(sram_addr), 32'(addr));
      chk("setup_dq",   32'(sram_dq), 32'(we ? wd : DQ_FLOAT));
      chk("setup_ub_n", 32'(ub_n), 32'(exp_ub));
      chk("setup_lb_n", 32'(lb_n), 32'(exp_lb));
      // Scrambled port inputs must not disturb the access already granted.
      drive_req(pb, 1'b1, ~we, ~addr, ~wd, ~be);
      for (int unsigned i = 0; i < AC; i++) begin
         tick();
         chk("strobe_we_n", 32'(we_n), 32'(exp_wen));
         chk("strobe_oe_n", 32'(oe_n), 32'(we));
         chk("strobe_ce_n", 32'(ce_n), 0);
         chk("strobe_addr", 32'(sram_addr), 32'(addr));
         chk("strobe_dq",   32'(sram_dq), 32'(we ? wd : exp_rd));
         chk("strobe_ack",  32'(pb ? b_ack : a_ack), 0);
      end
      tick();
      chk("rec_we_n",  32'(we_n), 1);
      chk("rec_oe_n",  32'(oe_n), 1);
      chk("rec_ce_n",  32'(ce_n), 0);
      chk("rec_addr",  32'(sram_addr), 32'(addr));
      chk("rec_dq",    32'(sram_dq), 32'(we ? wd : DQ_FLOAT));
      chk("rec_ub_n",  32'(ub_n), 32'(exp_ub));
      chk("rec_ack",   32'(pb ? b_ack : a_ack), 1);
      chk("rec_oack",  32'(pb ? a_ack : b_ack), 0);
      chk("rec_rdata", 32'(pb ? b_rdata : a_rdata), 32'(we ? own_rd : exp_rd));
      chk("rec_ordata", 32'(pb ? a_rdata : b_rdata), 32'(other_rd));
      drive_req(pb, 1'b0, 1'b0, '0, '0, '0);
      tick();
      chk("idle_ce_n", 32'(ce_n), 1);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_ack",  32'(pb ? b_ack : a_ack), 0);
      chk("idle_dq",   32'(sram_dq), 32'(DQ_FLOAT));
      chk("idle_ubl",  32'({ub_n, lb_n}), 3);
      chk("idle_we_n", 32'(we_n), 1);
      chk("idle_addr", 32'(sram_addr), 32'(addr));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int       n_ack;
      int       acks;
      bit [1:0] order [4];
      int       at    [4];
      rst = 1'b1;
      drive_req(1'b0, 1'b0, 1'b0, '0, '0, '0);
      drive_req(1'b1, 1'b0, 1'b0, '0, '0, '0);
      repeat (2) tick();
      chk("rst_ctrl",  32'({ce_n, we_n, oe_n, ub_n, lb_n}), 32'h1F);
      chk("rst_dq",    32'(sram_dq), 32'(DQ_FLOAT));
      chk("rst_addr",  32'(sram_addr), 0);
      chk("rst_acks",  32'({a_ack, b_ack}), 0);
      chk("rst_rdata", {a_rdata, b_rdata}, 0);
      chk("rst_busy",  32'(busy), 0);
      rst = 1'b0;
      tick();

      run_single(1'b0, 1'b1, 18'h00010, 16'h1234, 2'b11, 16'h0000);
      run_single(1'b0, 1'b0, 18'h00010, 16'h0000, 2'b00, 16'h1234);
      run_single(1'b1, 1'b1, 18'h00020, 16'h0000, 2'b11, 16'h0000);
      run_single(1'b1, 1'b1, 18'h00020, 16'hABCD, 2'b10, 16'h0000);
      run_single(1'b1, 1'b0, 18'h00020, 16'h0000, 2'b00, 16'hAB00);
      run_single(1'b1, 1'b1, 18'h00020, 16'h5555, 2'b00, 16'h0000);
      run_single(1'b1, 1'b0, 18'h00020, 16'h0000, 2'b00, 16'hAB00);

      // Both ports held requesting through reset: order must alternate starting with A.
      rst = 1'b1;
      drive_req(1'b0, 1'b1, 1'b0, 18'h00010, '0, '0);
      drive_req(1'b1, 1'b1, 1'b0, 18'h00020, '0, '0);
      tick();
      chk("rst_prio_busy", 32'(busy), 0);
      tick();
      rst = 1'b0;
      n_ack = 0;
      for (int i = 0; i < 4; i++) begin
         order[i] = 2'd3;
         at[i]    = 0;
      end
      for (int cyc = 0; cyc < 60 && n_ack < 4; cyc++) begin
         tick();
         if (a_ack && n_ack < 4) begin order[n_ack] = 2'd0; at[n_ack] = cyc; n_ack++; end
         if (b_ack && n_ack < 4) begin order[n_ack] = 2'd1; at[n_ack] = cyc; n_ack++; end
      end
      chk("cont_acks", 32'(n_ack), 4);
      chk("cont_first_lat", 32'(at[0]), 32'(AC + 1));
      for (int i = 0; i < 4; i++) chk("cont_order", 32'(order[i]), 32'(i % 2));
      for (int i = 1; i < 4; i++) chk("cont_spacing", 32'(at[i] - at[i-1]), 32'(AC + 3));
      chk("cont_a_rdata", 32'(a_rdata), 32'h1234);
      chk("cont_b_rdata", 32'(b_rdata), 32'hAB00);
      drive_req(1'b0, 1'b0, 1'b0, '0, '0, '0);
      drive_req(1'b1, 1'b0, 1'b0, '0, '0, '0);
      repeat (AC + 4) tick();
      chk("cont_idle_busy", 32'(busy), 0);

      // Reset during the first STROBE cycle of a write aborts it.
      drive_req(1'b0, 1'b1, 1'b1, 18'h00030, 16'h7777, 2'b11);
      tick();
      tick();
      chk("abort_pre_we_n", 32'(we_n), 0);
      rst = 1'b1;
      drive_req(1'b0, 1'b0, 1'b0, '0, '0, '0);
      tick();
      chk("abort_we_n", 32'(we_n), 1);
      chk("abort_oe_n", 32'(oe_n), 1);
      chk("abort_ce_n", 32'(ce_n), 1);
      chk("abort_dq",   32'(sram_dq), 32'(DQ_FLOAT));
      chk("abort_busy", 32'(busy), 0);
      chk("abort_rdata", 32'(a_rdata), 0);
      rst = 1'b0;
      acks = int'(a_ack) + int'(b_ack);
      for (int unsigned i = 0; i < AC + 4; i++) begin
         tick();
         acks += int'(a_ack) + int'(b_ack);
      end
      chk("abort_no_ack", 32'(acks), 0);
      run_single(1'b0, 1'b1, 18'h00030, 16'h4321, 2'b11, 16'h0000);
      run_single(1'b0, 1'b0, 18'h00030, 16'h0000, 2'b00, 16'h4321);

      tick();
      chk("bus_exclusion", 32'(viol), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
